// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: PC generator FSM states and instruction step sizes.
package riscv_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    localparam int unsigned STEP_C = 2;
    localparam int unsigned STEP_I = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: trap / redirect / pending redirect / stall / sequential,
// plus redirect alignment checking and pending-redirect bookkeeping.
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            inst_compressed,
    input  logic            pend_valid,
    input  logic [XLEN-1:0] pend_target,
    output logic [XLEN-1:0] pc_plus,
    output logic [XLEN-1:0] pc_next,
    output logic            pend_valid_next,
    output logic [XLEN-1:0] pend_target_next,
    output logic            misalign
);

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(IALIGN - 1);

    logic [XLEN-1:0] step;
    logic            target_bad;

    assign step       = (IALIGN == 2 && inst_compressed) ? XLEN'(STEP_C) : XLEN'(STEP_I);
    assign pc_plus    = pc + step;
    assign target_bad = |(redirect_target & LOW_MASK);

    always_comb begin
        pc_next          = pc_plus;
        pend_valid_next  = pend_valid;
        pend_target_next = pend_target;
        misalign         = 1'b0;

        if (trap_valid) begin
            pc_next         = trap_vector & ~LOW_MASK;
            pend_valid_next = 1'b0;
        end else if (redirect_valid && target_bad) begin
            // A bad target is dropped entirely: no load, no latch, pc holds.
            pc_next  = pc;
            misalign = 1'b1;
        end else if (!stall && redirect_valid) begin
            pc_next         = redirect_target;
            pend_valid_next = 1'b0;
        end else if (!stall && pend_valid) begin
            pc_next         = pend_target;
            pend_valid_next = 1'b0;
        end else if (stall) begin
            pc_next = pc;
            if (redirect_valid) begin
                pend_valid_next  = 1'b1;
                pend_target_next = redirect_target;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN FSM, PC and pending-redirect registers,
// and the misaligned-redirect error capture.
module pc_gen
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            inst_compressed,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            fetch_valid,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr
);

    pc_state_e       state, state_next;
    logic [XLEN-1:0] pc_q;
    logic            pend_valid;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] pc_next;
    logic            pend_valid_next;
    logic [XLEN-1:0] pend_target_next;
    logic            misalign;

    pc_next_sel #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_sel (
        .pc               (pc_q),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .trap_valid       (trap_valid),
        .trap_vector      (trap_vector),
        .inst_compressed  (inst_compressed),
        .pend_valid       (pend_valid),
        .pend_target      (pend_target),
        .pc_plus          (pc_plus),
        .pc_next          (pc_next),
        .pend_valid_next  (pend_valid_next),
        .pend_target_next (pend_target_next),
        .misalign         (misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        fetch_valid = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                state_next  = RUN;
                fetch_valid = 1'b1;
            end
            default: state_next = BOOT;
        endcase
    end

    // BOOT keeps pc parked on the reset vector so it is the first address fetched in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_VECTOR;
            pend_valid    <= 1'b0;
            pend_target   <= '0;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else if (state == RUN) begin
            pc_q         <= pc_next;
            pend_valid   <= pend_valid_next;
            pend_target  <= pend_target_next;
            misalign_err <= misalign;
            if (misalign) begin
                misalign_addr <= redirect_target;
            end
        end else begin
            pc_q         <= RESET_VECTOR;
            pend_valid   <= 1'b0;
            misalign_err <= 1'b0;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a vector table on an IALIGN=4 instance and
// hand-written sequences for reset and an IALIGN=2 instance.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        stall_a, rv_a, tv_a, comp_a;
    logic [31:0] rt_a, tvec_a;
    logic [31:0] pc_a, plus_a, addr_a;
    logic        fv_a, err_a;

    logic        stall_b, rv_b, tv_b, comp_b;
    logic [31:0] rt_b, tvec_b;
    logic [31:0] pc_b, plus_b, addr_b;
    logic        fv_b, err_b;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .IALIGN       (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall_a),
        .redirect_valid  (rv_a),
        .redirect_target (rt_a),
        .trap_valid      (tv_a),
        .trap_vector     (tvec_a),
        .inst_compressed (comp_a),
        .pc              (pc_a),
        .pc_plus         (plus_a),
        .fetch_valid     (fv_a),
        .misalign_err    (err_a),
        .misalign_addr   (addr_a)
    );

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0100),
        .IALIGN       (2)
    ) dut_c (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall_b),
        .redirect_valid  (rv_b),
        .redirect_target (rt_b),
        .trap_valid      (tv_b),
        .trap_vector     (tvec_b),
        .inst_compressed (comp_b),
        .pc              (pc_b),
        .pc_plus         (plus_b),
        .fetch_valid     (fv_b),
        .misalign_err    (err_b),
        .misalign_addr   (addr_b)
    );

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rt;
        logic        tv;
        logic [31:0] tvec;
        logic        comp;
        logic [31:0] pc;
        logic        fv;
        logic        err;
        logic [31:0] addr;
    } vec_t;

    typedef struct {
        string       name;
        bit          second;
        logic [31:0] pc;
        logic [31:0] plus;
        logic        fv;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[23];
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        stall_a = 0; rv_a = 0; rt_a = '0; tv_a = 0; tvec_a = '0; comp_a = 0;
        stall_b = 0; rv_b = 0; rt_b = '0; tv_b = 0; tvec_b = '0; comp_b = 0;
    endtask

    task automatic check_next();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        if (!e.second) begin
            cmp({e.name, ".pc"},    pc_a,          e.pc);
            cmp({e.name, ".plus"},  plus_a,        e.plus);
            cmp({e.name, ".fv"},    {31'd0, fv_a},  {31'd0, e.fv});
            cmp({e.name, ".err"},   {31'd0, err_a}, {31'd0, e.err});
            cmp({e.name, ".addr"},  addr_a,        e.addr);
        end else begin
            cmp({e.name, ".pc"},    pc_b,          e.pc);
            cmp({e.name, ".plus"},  plus_b,        e.plus);
            cmp({e.name, ".fv"},    {31'd0, fv_b},  {31'd0, e.fv});
            cmp({e.name, ".err"},   {31'd0, err_b}, {31'd0, e.err});
            cmp({e.name, ".addr"},  addr_b,        e.addr);
        end
    endtask

    task automatic apply(vec_t v, bit second, string name);
        exp_t e;
        if (second) begin
            stall_b = v.stall; rv_b = v.rv; rt_b = v.rt;
            tv_b = v.tv; tvec_b = v.tvec; comp_b = v.comp;
        end else begin
            stall_a = v.stall; rv_a = v.rv; rt_a = v.rt;
            tv_a = v.tv; tvec_a = v.tvec; comp_a = v.comp;
        end
        e.name   = name;
        e.second = second;
        e.pc     = v.pc;
        e.plus   = v.pc + ((second && v.comp) ? 32'd2 : 32'd4);
        e.fv     = v.fv;
        e.err    = v.err;
        e.addr   = v.addr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // stall, rv, rt, tv, tvec, comp  ->  pc, fv, err, addr
        tbl[0]  = '{0, 1, 32'h40,       1, 32'h80,  0, 32'h0,        1, 0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0,        0, 32'h0,   0, 32'h4,        1, 0, 32'h0};
        tbl[2]  = '{0, 0, 32'h0,        0, 32'h0,   0, 32'h8,        1, 0, 32'h0};
        tbl[3]  = '{1, 1, 32'h20,       0, 32'h0,   0, 32'h8,        1, 0, 32'h0};
        tbl[4]  = '{1, 0, 32'h0,        0, 32'h0,   0, 32'h8,        1, 0, 32'h0};
        tbl[5]  = '{0, 0, 32'h0,        0, 32'h0,   0, 32'h20,       1, 0, 32'h0};
        tbl[6]  = '{0, 0, 32'h0,        0, 32'h0,   0, 32'h24,       1, 0, 32'h0};
        tbl[7]  = '{1, 1, 32'h40,       1, 32'h103, 0, 32'h100,      1, 0, 32'h0};
        tbl[8]  = '{0, 0, 32'h0,        0, 32'h0,   0, 32'h104,      1, 0, 32'h0};
        tbl[9]  = '{0, 1, 32'h10,       0, 32'h0,   0, 32'h10,       1, 0, 32'h0};
        tbl[10] = '{0, 1, 32'h22,       0, 32'h0,   0, 32'h10,       1, 1, 32'h22};
        tbl[11] = '{0, 0, 32'h0,        0, 32'h0,   0, 32'h14,       1, 0, 32'h22};
        tbl[12] = '{0, 1, 32'hFFFF_FFFC, 0, 32'h0,  0, 32'hFFFF_FFFC, 1, 0, 32'h22};
        tbl[13] = '{0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        1, 0, 32'h22};
        tbl[14] = '{1, 1, 32'h80,       0, 32'h0,   0, 32'h0,        1, 0, 32'h22};
        tbl[15] = '{1, 1, 32'h90,       0, 32'h0,   0, 32'h0,        1, 0, 32'h22};
        tbl[16] = '{0, 1, 32'hA0,       0, 32'h0,   0, 32'hA0,       1, 0, 32'h22};
        tbl[17] = '{0, 0, 32'h0,        0, 32'h0,   0, 32'hA4,       1, 0, 32'h22};
        tbl[18] = '{1, 1, 32'h81,       0, 32'h0,   0, 32'hA4,       1, 1, 32'h81};
        tbl[19] = '{0, 0, 32'h0,        0, 32'h0,   0, 32'hA8,       1, 0, 32'h81};
        tbl[20] = '{1, 0, 32'h0,        0, 32'h0,   0, 32'hA8,       1, 0, 32'h81};
        tbl[21] = '{0, 0, 32'h0,        1, 32'h200, 0, 32'h200,      1, 0, 32'h81};
        tbl[22] = '{0, 0, 32'h0,        0, 32'h0,   1, 32'h204,      1, 0, 32'h81};

        idle_all();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.pc",   pc_a,           32'h0);
        cmp("reset.fv",   {31'd0, fv_a},  32'd0);
        cmp("reset.err",  {31'd0, err_a}, 32'd0);
        cmp("reset.addr", addr_a,         32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        cmp("boot.pc", pc_a,          32'h0);
        cmp("boot.fv", {31'd0, fv_a}, 32'd0);

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges with a stalled redirect in flight.
        @(negedge clk);
        stall_a = 1; rv_a = 1; rt_a = 32'h300;
        #1;
        rst = 1'b0;
        #1;
        cmp("async_rst.pc",    pc_a,           32'h0);
        cmp("async_rst.fv",    {31'd0, fv_a},  32'd0);
        cmp("async_rst.addr",  addr_a,         32'h0);
        cmp("async_rst.pc_c",  pc_b,           32'h100);
        idle_all();
        @(negedge clk);
        rst = 1'b1;
        apply('{0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0}, 1'b0, "post_rst0");
        apply('{0, 0, 32'h0, 0, 32'h0, 0, 32'h4, 1, 0, 32'h0}, 1'b0, "post_rst1");
        apply('{0, 0, 32'h0, 0, 32'h0, 0, 32'h8, 1, 0, 32'h0}, 1'b0, "post_rst2");

        // IALIGN=2 instance: its RUN entry happened at the same edge, then advanced by 4 twice.
        idle_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        apply('{0, 0, 32'h0,   0, 32'h0,   0, 32'h100, 1, 0, 32'h0},   1'b1, "c_boot");
        apply('{0, 0, 32'h0,   0, 32'h0,   1, 32'h102, 1, 0, 32'h0},   1'b1, "c_step2");
        apply('{0, 0, 32'h0,   0, 32'h0,   0, 32'h106, 1, 0, 32'h0},   1'b1, "c_step4");
        apply('{0, 1, 32'h10A, 0, 32'h0,   0, 32'h10A, 1, 0, 32'h0},   1'b1, "c_redir");
        apply('{0, 1, 32'h10B, 0, 32'h0,   0, 32'h10A, 1, 1, 32'h10B}, 1'b1, "c_misalign");
        apply('{0, 0, 32'h0,   1, 32'h203, 0, 32'h202, 1, 0, 32'h10B}, 1'b1, "c_trap");
        apply('{0, 1, 32'h2,   0, 32'h0,   0, 32'h2,   1, 0, 32'h10B}, 1'b1, "c_half");

        cmp("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
